// File: rtl/store_buffer.sv
// Write-back store buffer: an in-order FIFO of {address, data} stores that drains to data
// memory through a valid/ready port and forwards the newest matching store to loads.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        FwdHit,
  output logic [31:0] FwdData,
  output logic        BusValid,
  output logic [31:0] BusAdr,
  output logic [31:0] BusData,
  input  logic        BusReady,
  output logic        Empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_adr  [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_enq;
  logic          w_deq;
  logic          w_match;
  logic [AW-1:0] w_idx;
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // A full buffer refuses the store even if the head drains this same cycle.
  assign w_enq   = MemWrite & ~w_full;
  assign w_deq   = ~w_empty & BusReady;

  assign Stall    = w_full;
  assign Empty    = w_empty;
  assign BusValid = ~w_empty;
  assign BusAdr   = w_empty ? 32'd0 : r_adr[r_head];
  assign BusData  = w_empty ? 32'd0 : r_data[r_head];
  assign FwdHit   = w_fwd_hit;
  assign FwdData  = w_fwd_data;

  // Pointer, occupancy and entry storage updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_adr[i]  <= 32'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      if (w_enq) begin
        r_adr[r_tail]  <= DataAdr;
        r_data[r_tail] <= WriteData;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk valid entries oldest to newest so the last word-address match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = 32'd0;
    w_idx      = '0;
    w_match    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx      = r_head + AW'(i);
      w_match    = ~MemWrite && ((AW+1)'(i) < r_count) &&
                   (r_adr[w_idx][31:2] == DataAdr[31:2]);
      w_fwd_hit  = w_fwd_hit | w_match;
      w_fwd_data = w_match ? r_data[w_idx] : w_fwd_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer's contents.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, MemWrite, BusReady;
  logic [31:0] DataAdr, WriteData;
  logic        Stall, FwdHit, BusValid, Empty;
  logic [31:0] FwdData, BusAdr, BusData;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] qa[$];
  logic [31:0] qd[$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .Stall(Stall), .FwdHit(FwdHit), .FwdData(FwdData),
    .BusValid(BusValid), .BusAdr(BusAdr), .BusData(BusData),
    .BusReady(BusReady), .Empty(Empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs just after the falling edge and compare outputs with the model.
  task automatic drive(input logic rst, input logic mw, input logic [31:0] adr,
                       input logic [31:0] wd, input logic rdy);
    logic        e_hit;
    logic [31:0] e_fwd;
    reset = rst; MemWrite = mw; DataAdr = adr; WriteData = wd; BusReady = rdy;
    #1;
    e_hit = 1'b0;
    e_fwd = 32'd0;
    if (!mw) begin
      for (int i = 0; i < qa.size(); i++) begin
        if ((qa[i] >> 2) == (adr >> 2)) begin
          e_hit = 1'b1;
          e_fwd = qd[i];
        end
      end
    end
    check("stall",    {31'd0, Stall},    {31'd0, qa.size() == DEPTH});
    check("empty",    {31'd0, Empty},    {31'd0, qa.size() == 0});
    check("busvalid", {31'd0, BusValid}, {31'd0, qa.size() != 0});
    check("busadr",   BusAdr,  (qa.size() != 0) ? qa[0] : 32'd0);
    check("busdata",  BusData, (qd.size() != 0) ? qd[0] : 32'd0);
    check("fwdhit",   {31'd0, FwdHit},   {31'd0, e_hit});
    check("fwddata",  FwdData, e_fwd);
  endtask

  // Advance one clock and update the model from the inputs held across the edge.
  task automatic tick();
    bit full, deq, enq;
    @(posedge clk);
    if (reset) begin
      qa.delete();
      qd.delete();
    end else begin
      full = (qa.size() == DEPTH);
      deq  = (qa.size() != 0) && BusReady;
      enq  = MemWrite && !full;
      if (deq) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (enq) begin
        qa.push_back(DataAdr);
        qd.push_back(WriteData);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0; BusReady = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b1, 32'd4, 32'd1, 1'b1); tick();
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0); tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    check("rst_empty", {31'd0, Empty}, 32'd1);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    tick();

    // single store, no bypass in the accept cycle
    drive(1'b0, 1'b1, 32'd100, 32'd25, 1'b1);
    check("nobypass", {31'd0, BusValid}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd200, 32'd0, 1'b1);
    check("single_adr", BusAdr, 32'd100);
    check("single_dat", BusData, 32'd25);
    tick();
    drive(1'b0, 1'b0, 32'd200, 32'd0, 1'b0);
    check("single_empty", {31'd0, Empty}, 32'd1);
    tick();

    // fill and stall; BusReady does not relieve Stall in the same cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'd96 + 32'(4 * i), 32'(i + 1), 1'b0); tick();
    end
    drive(1'b0, 1'b1, 32'd112, 32'd5, 1'b0);
    check("full_stall", {31'd0, Stall}, 32'd1);
    tick();
    drive(1'b0, 1'b1, 32'd112, 32'd5, 1'b1); tick();
    drive(1'b0, 1'b1, 32'd112, 32'd5, 1'b0);
    check("unstall", {31'd0, Stall}, 32'd0);
    check("unstall_adr", BusAdr, 32'd100);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1); tick();
    end

    // forwarding picks the newest match on word address
    drive(1'b0, 1'b1, 32'd96, 32'd7, 1'b0); tick();
    drive(1'b0, 1'b1, 32'd96, 32'd9, 1'b0); tick();
    drive(1'b0, 1'b0, 32'd98, 32'd0, 1'b0);
    check("fwd_hit", {31'd0, FwdHit}, 32'd1);
    check("fwd_data", FwdData, 32'd9);
    tick();
    drive(1'b0, 1'b0, 32'd104, 32'd0, 1'b0);
    check("fwd_miss", FwdData, 32'd0);
    tick();

    // reset with three entries pending
    drive(1'b0, 1'b1, 32'd200, 32'd11, 1'b0); tick();
    drive(1'b1, 1'b1, 32'd300, 32'd12, 1'b1); tick();
    drive(1'b0, 1'b0, 32'd98, 32'd0, 1'b0);
    check("rst_mid_valid", {31'd0, BusValid}, 32'd0);
    check("rst_mid_fwd", {31'd0, FwdHit}, 32'd0);
    tick();

    // simultaneous enqueue/dequeue, then back-to-back stores across pointer wrap
    drive(1'b0, 1'b1, 32'd400, 32'd1, 1'b0); tick();
    drive(1'b0, 1'b1, 32'd404, 32'd2, 1'b0); tick();
    drive(1'b0, 1'b1, 32'd408, 32'd3, 1'b1); tick();
    check("simul_count", qa.size(), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 32'd500 + 32'(4 * i), 32'(100 + i), 1'b1); tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1); tick();
    end

    // random traffic on a small address window to exercise forwarding
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6),
            32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
            $urandom(), ($urandom_range(0, 1) == 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of buffered stores; a power of two, at least 2.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port MemWrite  input  1  core store request this cycle.
REQ-005 The block SHALL have port DataAdr  input  32  store address; load address when MemWrite=0.
REQ-006 The block SHALL have port WriteData  input  32  store data.
REQ-007 The block SHALL have port Stall  output  1  buffer full; core holds its store.
REQ-008 The block SHALL have port FwdHit  output  1  load address matches a buffered store.
REQ-009 The block SHALL have port FwdData  output  32  data of the newest matching buffered store.
REQ-010 The block SHALL have port BusValid  output  1  head entry offered to data memory.
REQ-011 The block SHALL have port BusAdr  output  32  head entry address.
REQ-012 The block SHALL have port BusData  output  32  head entry data.
REQ-013 The block SHALL have port BusReady  input  1  data memory accepts the offered entry.
REQ-014 The block SHALL have port Empty  output  1  no entries buffered.

Function
REQ-015 The block SHALL be a FIFO of DEPTH {address, data} entries with head pointer, tail pointer and occupancy count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-016 The block SHALL drive Stall = (count==DEPTH) and Empty = (count==0), combinationally from registered count only.
REQ-017 The block SHALL enqueue {DataAdr, WriteData} at tail on a rising edge with MemWrite=1 and Stall=0; tail advances, count increments.
REQ-018 The block SHALL ignore MemWrite=1 while Stall=1: no state change; the core re-presents the store.
REQ-019 The block SHALL drive BusValid = (count!=0), with BusAdr/BusData = head entry.
REQ-020 The block SHALL dequeue on a rising edge with BusValid=1 and BusReady=1; head advances, count decrements.
REQ-021 The block SHALL hold BusAdr/BusData stable while BusValid=1 and BusReady=0.
REQ-022 The block SHALL, on a cycle with both enqueue and dequeue, perform both and leave count unchanged.
REQ-023 The block SHALL NOT enqueue when full even if a dequeue occurs in the same cycle; Stall is not relieved combinationally by BusReady.
REQ-024 The block SHALL NOT bypass: a store accepted into an empty buffer appears on BusValid one cycle later, never in the accept cycle.
REQ-025 The block SHALL present stores on the bus strictly in acceptance order.
REQ-026 The block SHALL, when MemWrite=0, compare DataAdr[31:2] against the address[31:2] of every valid entry; on any match, FwdHit=1 and FwdData = data of the most recently enqueued match.
REQ-027 The block SHALL drive FwdHit=0 and FwdData=0 when MemWrite=1 or no entry matches.
REQ-028 The block SHALL exclude an entry dequeued in the current cycle from no comparison: forwarding reflects registered state at the start of the cycle.
REQ-029 The block SHALL drive BusAdr/BusData = 0 while Empty=1.

Reset
REQ-030 The block SHALL, on reset=1 at a rising edge, clear count, head, tail and all entries to 0, discarding pending stores, regardless of MemWrite or BusReady that cycle.
REQ-031 The block SHALL, after reset, drive Stall=0, Empty=1, BusValid=0, BusAdr=0, BusData=0, FwdHit=0, FwdData=0.

Verification
REQ-032 Single store: MemWrite=1, DataAdr=100, WriteData=25, BusReady=1 -> next cycle BusValid=1, BusAdr=100, BusData=25; following cycle Empty=1.
REQ-033 Fill and stall: BusReady=0, stores to 96,100,104,108 -> Stall=1 after 4th; 5th store (112) ignored; BusReady=1 for one cycle -> Stall=0, BusAdr=100; 112 re-presented is accepted as last.
REQ-034 Forwarding: store 96=7 then 96=9, BusReady=0, load DataAdr=98 -> FwdHit=1, FwdData=9; load 104 -> FwdHit=0, FwdData=0.
REQ-035 Simultaneous: count=2, BusReady=1, MemWrite=1 -> count stays 2, bus order preserved; 10 back-to-back stores with BusReady=1 drain in order across pointer wrap.
REQ-036 Reset mid-operation: 3 entries pending, BusReady=0, reset=1 one cycle -> next cycle BusValid=0, Empty=1, Stall=0, FwdHit=0 for previously stored addresses.
